// File: rtl/ssc_master_if.sv
// Request/response handshake and SSC bus lines between the transaction source,
// the ssc_master and the downstream port mux.
interface ssc_master_if #(
    parameter int CMD_BITS  = 16,
    parameter int DATA_BITS = 32
);
    logic                 start;
    logic                 ready;
    logic [4:0]           port;
    logic                 write;
    logic [CMD_BITS-1:0]  cmd;
    logic [DATA_BITS-1:0] wrData;
    logic [DATA_BITS-1:0] rdData;
    logic                 done;
    logic                 err;
    logic [4:0]           sscPort;
    logic                 sscClk1;
    logic                 sscSync1;
    logic                 sscData1Out;
    logic                 sscData1In;

    modport master (
        input  start, port, write, cmd, wrData, sscData1In,
        output ready, rdData, done, err, sscPort, sscClk1, sscSync1, sscData1Out
    );

    modport slave (
        output start, port, write, cmd, wrData, sscData1In,
        input  ready, rdData, done, err, sscPort, sscClk1, sscSync1, sscData1Out
    );
endinterface

// File: rtl/ssc_master.sv
// SSC bus master: selects a mux port, shifts a command word plus a write or
// read data word over sync/clk/data, and returns read data with a done pulse.
module ssc_master #(
    parameter int CLK_DIV   = 4,
    parameter int CMD_BITS  = 16,
    parameter int DATA_BITS = 32,
    parameter int SETUP_CYC = 2,
    parameter int NUM_PORTS = 25
) (
    input  logic         clk,
    input  logic         reset,
    ssc_master_if.master bus
);
    localparam int N  = CMD_BITS + DATA_BITS;
    localparam int BW = $clog2(N + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(SETUP_CYC + 1);
    localparam logic [5:0] NP = 6'(NUM_PORTS);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]           state;
    logic [BW-1:0]        bit_cnt;
    logic [DW-1:0]        div_cnt;
    logic [SW-1:0]        set_cnt;
    logic [N-1:0]         tx;
    logic [DATA_BITS-1:0] rx;
    logic                 wr_q;

    logic div_last, set_last, bit_last;
    assign div_last = (div_cnt == DW'(CLK_DIV - 1));
    assign set_last = (set_cnt == SW'(SETUP_CYC - 1));
    assign bit_last = (bit_cnt == BW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            div_cnt         <= '0;
            set_cnt         <= '0;
            tx              <= '0;
            rx              <= '0;
            wr_q            <= 1'b0;
            bus.ready       <= 1'b1;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            bus.rdData      <= '0;
            bus.sscPort     <= '0;
            bus.sscClk1     <= 1'b1;
            bus.sscSync1    <= 1'b1;
            bus.sscData1Out <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.ready <= 1'b0;
                        wr_q      <= bus.write;
                        tx        <= {bus.cmd, bus.write ? bus.wrData : {DATA_BITS{1'b0}}};
                        if ({1'b0, bus.port} < NP) begin
                            bus.sscPort <= bus.port;
                            set_cnt     <= '0;
                            state       <= SETUP;
                        end else begin
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                SETUP: begin
                    if (set_last) begin
                        state           <= SHIFT;
                        bus.sscSync1    <= 1'b0;
                        bus.sscClk1     <= 1'b0;
                        bus.sscData1Out <= tx[N-1];
                        tx              <= {tx[N-2:0], 1'b0};
                        div_cnt         <= '0;
                        bit_cnt         <= '0;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // Slave data is taken once per bit, in the first high-phase cycle.
                    if (bus.sscClk1 && div_cnt == '0 && !wr_q && bit_cnt >= BW'(CMD_BITS))
                        rx <= {rx[DATA_BITS-2:0], bus.sscData1In};
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!bus.sscClk1) begin
                            bus.sscClk1 <= 1'b1;
                        end else if (bit_last) begin
                            state           <= HOLD;
                            bus.sscSync1    <= 1'b1;
                            bus.sscData1Out <= 1'b0;
                            set_cnt         <= '0;
                        end else begin
                            bus.sscClk1     <= 1'b0;
                            bit_cnt         <= bit_cnt + 1'b1;
                            bus.sscData1Out <= tx[N-1];
                            tx              <= {tx[N-2:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (set_last) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        if (!wr_q)
                            bus.rdData <= rx;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
